// File: rtl/rf_read_port_arbiter_pkg.sv
// rf_read_port_arbiter_pkg: shared sizes and register-file read types for the operand-load stage
package rf_read_port_arbiter_pkg;
    localparam int NUM_REQ      = 8;
    localparam int NUM_PORTS    = 4;
    localparam int TAG_W        = 7;
    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 3;
    localparam int AGE_W        = $clog2(STARVE_LIMIT + 1);
    localparam int REQ_W        = $clog2(NUM_REQ);
    localparam int PORT_W       = $clog2(NUM_PORTS);
    typedef logic [TAG_W-1:0] RFTag;
    typedef struct packed {
        logic valid;
        RFTag tag;
    } RF_ReadReq;
    typedef logic [PORT_W-1:0] RFPortIdx_t;
    typedef logic [REQ_W-1:0] RFReqIdx_t;
    typedef logic [AGE_W-1:0] RFAge_t;
endpackage

// File: rtl/rf_read_port_arbiter_alloc.sv
// rf_port_alloc: combinational port allocation over requesters already sorted into priority order
module rf_port_alloc
    import rf_read_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0]              slot_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   slot_tag,
    output logic [NUM_REQ-1:0]              slot_grant,
    output logic [NUM_REQ-1:0][PORT_W-1:0]  slot_port,
    output RF_ReadReq [NUM_PORTS-1:0]       port_req
);
    // walk slots in priority order: share a port on tag match, else take the next free port
    always_comb begin
        int used;
        logic hit;
        slot_grant = '0;
        slot_port  = '0;
        used       = 0;
        for (int p = 0; p < NUM_PORTS; p++) port_req[p] = {1'b0, {TAG_W{1'bx}}};
        for (int k = 0; k < NUM_REQ; k++) begin
            hit = 1'b0;
            if (slot_valid[k]) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (!hit && port_req[p].valid && port_req[p].tag == slot_tag[k]) begin
                        hit          = 1'b1;
                        slot_port[k] = RFPortIdx_t'(p);
                    end
                end
                if (hit) begin
                    slot_grant[k] = 1'b1;
                end else if (used < NUM_PORTS) begin
                    port_req[used] = {1'b1, slot_tag[k]};
                    slot_port[k]   = RFPortIdx_t'(used);
                    slot_grant[k]  = 1'b1;
                    used           = used + 1;
                end
            end
        end
    end
endmodule

// File: rtl/rf_read_port_arbiter.sv
// rf_read_port_arbiter: shares RF read ports among operand lookups with round-robin and starvation guard
module rf_read_port_arbiter
    import rf_read_port_arbiter_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            IN_flush,
    input  logic [NUM_REQ-1:0]              IN_reqValid,
    input  logic [NUM_REQ*TAG_W-1:0]        IN_reqTag,
    output logic [NUM_REQ-1:0]              OUT_stall,
    output logic [NUM_PORTS*(1+TAG_W)-1:0]  OUT_rfReadReq,
    input  logic [NUM_PORTS*DATA_W-1:0]     IN_rfReadData,
    output logic [NUM_REQ*DATA_W-1:0]       OUT_data,
    output logic [NUM_REQ-1:0]              OUT_dataValid
);
    RFReqIdx_t                          rr_ptr;
    logic [NUM_REQ-1:0][AGE_W-1:0]      age;
    logic [NUM_REQ-1:0]                 grant_valid_r;
    logic [NUM_REQ-1:0][PORT_W-1:0]     port_sel_r;
    logic [NUM_REQ-1:0][REQ_W-1:0]      order;
    logic [NUM_REQ-1:0]                 slot_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]      slot_tag;
    logic [NUM_REQ-1:0]                 slot_grant;
    logic [NUM_REQ-1:0][PORT_W-1:0]     slot_port;
    RF_ReadReq [NUM_PORTS-1:0]          port_req;
    logic [NUM_REQ-1:0]                 granted;
    logic [NUM_REQ-1:0][PORT_W-1:0]     port_sel;
    logic [NUM_REQ-1:0]                 stall_raw;
    logic                               any_stall;
    RFReqIdx_t                          first_stall;

    // priority order: lowest starved requester first, then the rest rotated from rr_ptr
    always_comb begin
        int pos;
        int starve;
        int idx;
        starve = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (starve < 0 && IN_reqValid[i] && age[i] == RFAge_t'(STARVE_LIMIT)) starve = i;
        order = '0;
        pos   = 0;
        if (starve >= 0) begin
            order[0] = RFReqIdx_t'(starve);
            pos      = 1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (idx != starve) begin
                order[pos] = RFReqIdx_t'(idx);
                pos        = pos + 1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            slot_valid[k] = IN_reqValid[order[k]];
            slot_tag[k]   = IN_reqTag[order[k]*TAG_W +: TAG_W];
        end
    end

    rf_port_alloc u_alloc (
        .slot_valid (slot_valid),
        .slot_tag   (slot_tag),
        .slot_grant (slot_grant),
        .slot_port  (slot_port),
        .port_req   (port_req)
    );

    // map slot results back to requesters and find the first stall in priority order
    always_comb begin
        granted     = '0;
        port_sel    = '0;
        stall_raw   = '0;
        any_stall   = 1'b0;
        first_stall = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            granted[order[k]]  = slot_grant[k];
            port_sel[order[k]] = slot_port[k];
            if (slot_valid[k] && !slot_grant[k]) begin
                stall_raw[order[k]] = 1'b1;
                if (!any_stall) first_stall = order[k];
                any_stall = 1'b1;
            end
        end
    end

    // outputs are quiet while reset is held; returned data follows last cycle's grant
    always_comb begin
        OUT_stall     = rst ? '0 : stall_raw;
        OUT_dataValid = grant_valid_r;
        for (int p = 0; p < NUM_PORTS; p++)
            OUT_rfReadReq[p*(1+TAG_W) +: 1+TAG_W] = {port_req[p].valid && !rst, port_req[p].tag};
        for (int i = 0; i < NUM_REQ; i++)
            OUT_data[i*DATA_W +: DATA_W] = grant_valid_r[i] ? IN_rfReadData[port_sel_r[i]*DATA_W +: DATA_W]
                                                            : {DATA_W{1'bx}};
    end

    // grant pipeline, rotation pointer and per-requester stall ages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            age           <= '0;
            grant_valid_r <= '0;
            port_sel_r    <= '0;
        end else begin
            grant_valid_r <= granted & {NUM_REQ{!IN_flush}};
            port_sel_r    <= port_sel;
            if (!IN_flush && any_stall) rr_ptr <= first_stall;
            for (int i = 0; i < NUM_REQ; i++)
                age[i] <= (IN_flush || !stall_raw[i]) ? '0
                        : (age[i] == RFAge_t'(STARVE_LIMIT)) ? age[i] : age[i] + RFAge_t'(1);
        end
    end
endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// tb_rf_read_port_arbiter: directed and random stimulus against a queue-based allocation model
module tb_rf_read_port_arbiter;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [7:0]    req_valid = '0;
    logic [55:0]   req_tag = '0;
    logic [7:0]    stall;
    logic [31:0]   rd_req;
    logic [255:0]  rd_data = '0;
    logic [511:0]  data;
    logic [7:0]    data_valid;

    int checks = 0;
    int errors = 0;
    int tg[8];

    int m_rr = 0;
    int m_age[8];
    bit m_gv[8];
    int m_ps[8];
    bit e_grant[8];
    bit e_stall[8];
    int e_ps[8];
    int e_ptag[$];
    int e_first;
    bit e_any;

    rf_read_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .IN_flush      (flush),
        .IN_reqValid   (req_valid),
        .IN_reqTag     (req_tag),
        .OUT_stall     (stall),
        .OUT_rfReadReq (rd_req),
        .IN_rfReadData (rd_data),
        .OUT_data      (data),
        .OUT_dataValid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_rr = 0;
        for (int i = 0; i < 8; i++) begin
            m_age[i] = 0;
            m_gv[i]  = 0;
            m_ps[i]  = 0;
        end
    endfunction

    function automatic void model_eval();
        int ord[$];
        int starve;
        int found;
        starve = -1;
        for (int i = 0; i < 8; i++)
            if (starve < 0 && req_valid[i] && m_age[i] == 3) starve = i;
        if (starve >= 0) ord.push_back(starve);
        for (int k = 0; k < 8; k++)
            if ((m_rr + k) % 8 != starve) ord.push_back((m_rr + k) % 8);
        e_ptag.delete();
        e_any = 0;
        e_first = 0;
        for (int i = 0; i < 8; i++) begin
            e_grant[i] = 0;
            e_stall[i] = 0;
            e_ps[i]    = 0;
        end
        foreach (ord[k]) begin
            int i;
            i = ord[k];
            if (req_valid[i]) begin
                found = -1;
                foreach (e_ptag[j]) if (found < 0 && e_ptag[j] == tg[i]) found = j;
                if (found >= 0) begin
                    e_grant[i] = 1;
                    e_ps[i]    = found;
                end else if (e_ptag.size() < 4) begin
                    e_ptag.push_back(tg[i]);
                    e_grant[i] = 1;
                    e_ps[i]    = e_ptag.size() - 1;
                end else begin
                    e_stall[i] = 1;
                    if (!e_any) e_first = i;
                    e_any = 1;
                end
            end
        end
    endfunction

    function automatic void model_update();
        for (int i = 0; i < 8; i++) begin
            m_age[i] = (flush || !e_stall[i]) ? 0 : (m_age[i] < 3 ? m_age[i] + 1 : 3);
            m_gv[i]  = e_grant[i] && !flush;
            m_ps[i]  = e_ps[i];
        end
        if (!flush && e_any) m_rr = e_first;
    endfunction

    task automatic run_cycle(input logic [7:0] v, input bit f);
        logic [7:0] es;
        logic [7:0] ev;
        logic [7:0] gv;
        logic [3:0] epv;
        logic [3:0] gpv;
        @(negedge clk);
        req_valid = v;
        flush = f;
        for (int i = 0; i < 8; i++) req_tag[i*7 +: 7] = 7'(tg[i]);
        for (int p = 0; p < 4; p++) rd_data[p*64 +: 64] = {$urandom, $urandom};
        #2;
        model_eval();
        for (int i = 0; i < 8; i++) begin
            es[i] = e_stall[i];
            ev[i] = m_gv[i];
        end
        check("stall", stall, es);
        for (int p = 0; p < 4; p++) begin
            epv[p] = p < e_ptag.size();
            gpv[p] = rd_req[p*8 + 7];
        end
        check("port_valid", gpv, epv);
        foreach (e_ptag[p]) check("port_tag", rd_req[p*8 +: 7], e_ptag[p]);
        gv = data_valid;
        check("data_valid", gv, ev);
        for (int i = 0; i < 8; i++)
            if (m_gv[i]) check("data", data[i*64 +: 64], rd_data[m_ps[i]*64 +: 64]);
        @(posedge clk);
        model_update();
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 8; i++) tg[i] = i + 20;
        @(negedge clk);
        req_valid = 8'hff;
        for (int i = 0; i < 8; i++) req_tag[i*7 +: 7] = 7'(tg[i]);
        #2;
        check("rst_stall", stall, 8'h00);
        check("rst_port_valid", {rd_req[31], rd_req[23], rd_req[15], rd_req[7]}, 4'h0);
        check("rst_data_valid", data_valid, 8'h00);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) tg[i] = i + 1;
        run_cycle(8'h0f, 0);
        run_cycle(8'h00, 0);

        for (int i = 0; i < 8; i++) tg[i] = i + 10;
        run_cycle(8'h3f, 0);
        run_cycle(8'h3f, 0);

        for (int i = 0; i < 8; i++) tg[i] = 9;
        run_cycle(8'hff, 0);
        run_cycle(8'h00, 0);

        for (int i = 0; i < 8; i++) tg[i] = i + 30;
        run_cycle(8'h07, 1);
        run_cycle(8'h00, 0);

        run_cycle(8'hff, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_data_valid", data_valid, 8'h00);
        check("async_rst_stall", stall, 8'h00);
        check("async_rst_port_valid", {rd_req[31], rd_req[23], rd_req[15], rd_req[7]}, 4'h0);
        model_reset();
        @(negedge clk);
        req_valid = '0;
        flush = 1'b0;
        rst = 1'b0;
        run_cycle(8'h3f, 0);
        run_cycle(8'h00, 0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) tg[i] = $urandom_range(0, 5);
            run_cycle(8'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
